// File: rtl/output_drain.sv
// -----------------------------------------------------------------------------
// output_drain
//
// Drains a contiguous run of rows from the 64 x 512-bit output buffer and
// serialises each row into four 128-bit beats on a valid/ready stream toward
// the write-back/DMA path. While a drain is active, this block owns the
// buffer's read port.
//
// Each row is read with the buffer's one-cycle latency and lands in a
// two-entry row queue. The head row is emitted beat by beat. A new read is
// issued only if the rows already held plus the read still in flight leave
// room in the queue. The queue therefore never overflows, and with m_ready
// held high the stream runs at one beat per cycle.
//
// Ports
//   CLK         single clock, rising edge
//   RST         synchronous, active-high reset
//   start       one-cycle request, accepted only while idle
//   base_addr   first row to drain (sampled with start)
//   row_cnt     number of rows, 0..64 (sampled with start)
//   busy        drain in progress (cycle after start until done)
//   done        one-cycle completion pulse
//   buf_cen     buffer chip enable, active-low (low = read this cycle)
//   buf_wen     buffer write enable, active-low, tied high
//   buf_retn    buffer retention, tied high
//   buf_a       buffer row address; holds its last value when idle
//   buf_q       buffer read data, valid the cycle after buf_cen low
//   m_data      stream beat, row bits [128k+127:128k] for beat k
//   m_valid     stream valid
//   m_ready     stream ready
//   m_last      marks beat 3 of the final row
// -----------------------------------------------------------------------------
module output_drain #(
  parameter int ADDR_W = 6,
  parameter int ROW_W  = 512,
  parameter int BEAT_W = 128
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   row_cnt,
  output logic              busy,
  output logic              done,
  output logic              buf_cen,
  output logic              buf_wen,
  output logic              buf_retn,
  output logic [ADDR_W-1:0] buf_a,
  input  logic [ROW_W-1:0]  buf_q,
  output logic [BEAT_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int BEATS      = ROW_W / BEAT_W;
  localparam int BEAT_IDX_W = $clog2(BEATS);
  localparam int CNT_W      = ADDR_W + 1;
  localparam logic [BEAT_IDX_W-1:0] BEAT_LAST = BEAT_IDX_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t state;
  state_t state_nxt;

  // Job parameters captured when start is accepted
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  cnt_q;

  // Progress counters: rows read from the buffer, and rows fully emitted
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  popped;

  // Set when a read was issued last cycle, so buf_q carries a row this cycle
  logic              inflight;

  // Address of the most recent read; buf_a shows it while no read is issued
  logic [ADDR_W-1:0] last_a;

  // Two-row skid queue, each row stored as BEATS packed beats
  logic [BEATS-1:0][BEAT_W-1:0] q_mem [2];
  logic                         wr_ptr;
  logic                         rd_ptr;
  logic [1:0]                   count;
  logic [BEAT_IDX_W-1:0]        beat;

  // Datapath control
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic [1:0]        occupancy;
  logic              hs;
  logic              pop;
  logic              last_row;
  logic              accept;

  assign accept     = (state == S_IDLE) && start;

  // Rows held in the queue plus any row still in flight. A read may only be
  // issued when this leaves a free slot for the row it will return.
  assign occupancy  = count + {1'b0, inflight};
  assign issue      = (state == S_RUN) && (occupancy < 2'd2) && (issued < cnt_q);

  // The address wraps modulo 64 because it is truncated to ADDR_W bits.
  assign issue_addr = base_q + issued[ADDR_W-1:0];

  assign hs         = m_valid && m_ready;
  assign pop        = hs && (beat == BEAT_LAST);
  assign last_row   = (popped == cnt_q - CNT_W'(1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: assign a default first so every path drives state_nxt and no latch
  // is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          // A zero-row job passes through DRAIN for one cycle. The queue is
          // already empty, so it reaches FIN on the next edge and done lands
          // two cycles after start.
          state_nxt = (row_cnt == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (issue && (issued + CNT_W'(1) == cnt_q)) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Finish as soon as the final pop happens. done then follows the last
        // handshake by exactly one cycle.
        if (!inflight && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
          state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy     = (state == S_RUN) || (state == S_DRAIN);
    done     = (state == S_FIN);
    buf_cen  = !issue;
    buf_wen  = 1'b1;
    buf_retn = 1'b1;
    buf_a    = issue ? issue_addr : last_a;
    m_valid  = (count != 2'd0);
    // The head row and beat index are registered, so m_data and m_last stay
    // stable until the handshake.
    m_data   = m_valid ? q_mem[rd_ptr][beat] : '0;
    m_last   = m_valid && (beat == BEAT_LAST) && last_row;
  end

  // ---------------------------------------------------------------------------
  // Job bookkeeping, read issue, and queue control
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      base_q   <= '0;
      cnt_q    <= '0;
      issued   <= '0;
      popped   <= '0;
      inflight <= 1'b0;
      last_a   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      beat     <= '0;
    end else begin
      if (accept) begin
        base_q <= base_addr;
        cnt_q  <= row_cnt;
        issued <= '0;
        popped <= '0;
      end

      inflight <= issue;
      if (issue) begin
        issued <= issued + CNT_W'(1);
        last_a <= issue_addr;
      end

      if (inflight) begin
        wr_ptr <= ~wr_ptr;
      end

      if (hs) begin
        beat <= pop ? '0 : beat + 1'b1;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        popped <= popped + CNT_W'(1);
      end

      unique case ({inflight, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the row storage is deliberately left unreset. count gates m_valid,
  // so stale contents are never observed, and resetting 1 Kbit of data flops
  // buys nothing.
  always_ff @(posedge CLK) begin
    if (!RST && inflight) begin
      q_mem[wr_ptr] <= buf_q;
    end
  end

endmodule
